id_ex_stage: RTL

- Decode stage plus ID/EX pipeline register of the 16-bit 5-stage core.
- Takes the IF/ID instruction, decodes it, and drives the register-file read addresses.
- Returns read data with a same-cycle write-back bypass, because the register file writes on posedge and reads combinationally.
- Detects load-use hazards, inserts bubbles on stall or flush, and registers everything the EX stage consumes.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/id_decoder.sv | 78 +++++++
 rtl/id_ex_stage.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared opcodes, ALU encodings and control bundle
// for the 16-bit 5-stage core.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_ADDI = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_BEQ  = 4'd7;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;

    typedef enum logic {
        SRC2_RT = 1'b0,
        SRC2_RD = 1'b1
    } src2_sel_e;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
    } ctrl_t;

endpackage

// File: rtl/id_decoder.sv
// Opcode decoder: control bundle plus which
// register sources the instruction really reads.
module id_decoder
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output ctrl_t      ctrl,
    output logic       uses_rs,
    output logic       uses_src2,
    output src2_sel_e  src2_sel
);

    always_comb begin
        ctrl      = '0;
        uses_rs   = 1'b0;
        uses_src2 = 1'b0;
        src2_sel  = SRC2_RT;
        unique case (1'b1)
            (opcode == OP_ADD): begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.reg_write = 1'b1;
                uses_rs        = 1'b1;
                uses_src2      = 1'b1;
            end
            (opcode == OP_SUB): begin
                ctrl.alu_op    = ALU_SUB;
                ctrl.reg_write = 1'b1;
                uses_rs        = 1'b1;
                uses_src2      = 1'b1;
            end
            (opcode == OP_AND): begin
                ctrl.alu_op    = ALU_AND;
                ctrl.reg_write = 1'b1;
                uses_rs        = 1'b1;
                uses_src2      = 1'b1;
            end
            (opcode == OP_OR): begin
                ctrl.alu_op    = ALU_OR;
                ctrl.reg_write = 1'b1;
                uses_rs        = 1'b1;
                uses_src2      = 1'b1;
            end
            (opcode == OP_ADDI): begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                uses_rs        = 1'b1;
            end
            (opcode == OP_LW): begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.reg_write = 1'b1;
                uses_rs        = 1'b1;
            end
            // Stores and branches compare/write rd, so it is read on port 2
            (opcode == OP_SW): begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                uses_rs        = 1'b1;
                uses_src2      = 1'b1;
                src2_sel       = SRC2_RD;
            end
            (opcode == OP_BEQ): begin
                ctrl.alu_op    = ALU_SUB;
                ctrl.branch    = 1'b1;
                uses_rs        = 1'b1;
                uses_src2      = 1'b1;
                src2_sel       = SRC2_RD;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage and ID/EX pipeline register with
// write-back bypass, load-use stall and bubbles.
module id_ex_stage #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int REG_AW = cpu_pkg::REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_id_valid,
    input  logic [DATA_W-1:0] if_id_instr,
    input  logic [DATA_W-1:0] if_id_pc,
    input  logic              flush,
    output logic [REG_AW-1:0] read_register1,
    output logic [REG_AW-1:0] read_register2,
    input  logic [DATA_W-1:0] read_data1,
    input  logic [DATA_W-1:0] read_data2,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_write_register,
    input  logic [DATA_W-1:0] wb_write_data,
    output logic              stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [REG_AW-1:0] ex_rd,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [DATA_W-1:0] ex_data1,
    output logic [DATA_W-1:0] ex_data2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [2:0]        ex_alu_op,
    output logic              ex_alu_src,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_branch,
    output logic [CNT_W-1:0]  stall_count
);

    import cpu_pkg::*;

    logic [3:0]        opcode;
    logic [REG_AW-1:0] rd, rs, rt;
    ctrl_t             dec_ctrl;
    logic              uses_rs, uses_src2;
    src2_sel_e         src2_sel;

    assign opcode = if_id_instr[15:12];
    assign rd     = if_id_instr[11:8];
    assign rs     = if_id_instr[7:4];
    assign rt     = if_id_instr[3:0];

    id_decoder u_dec (
        .opcode    (opcode),
        .ctrl      (dec_ctrl),
        .uses_rs   (uses_rs),
        .uses_src2 (uses_src2),
        .src2_sel  (src2_sel)
    );

    assign read_register1 = rs;
    assign read_register2 = (src2_sel == SRC2_RD) ? rd : rt;

    logic [DATA_W-1:0] op1, op2;

    // Register file writes on posedge, so its read port lags by a cycle
    always_comb begin
        op1 = read_data1;
        op2 = read_data2;
        if (wb_reg_write && (wb_write_register == read_register1))
            op1 = wb_write_data;
        if (wb_reg_write && (wb_write_register == read_register2))
            op2 = wb_write_data;
    end

    logic              ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0] ex_pc_q, ex_pc_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
    logic [REG_AW-1:0] ex_rs_q, ex_rs_d;
    logic [REG_AW-1:0] ex_rt_q, ex_rt_d;
    logic [DATA_W-1:0] ex_data1_q, ex_data1_d;
    logic [DATA_W-1:0] ex_data2_q, ex_data2_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
    ctrl_t             ex_ctrl_q, ex_ctrl_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic src1_hit, src2_hit, hazard;

    assign src1_hit = uses_rs && (ex_rd_q == read_register1);
    assign src2_hit = uses_src2 && (ex_rd_q == read_register2);
    assign hazard   = if_id_valid && ex_valid_q && ex_ctrl_q.mem_read
                    && (src1_hit || src2_hit);
    assign stall    = hazard && !flush;

    always_comb begin
        ex_valid_d = 1'b0;
        ex_pc_d    = '0;
        ex_rd_d    = '0;
        ex_rs_d    = '0;
        ex_rt_d    = '0;
        ex_data1_d = '0;
        ex_data2_d = '0;
        ex_imm_d   = '0;
        ex_ctrl_d  = '0;
        if (!(flush || stall)) begin
            ex_valid_d = if_id_valid;
            ex_pc_d    = if_id_pc;
            ex_rd_d    = rd;
            ex_rs_d    = rs;
            ex_rt_d    = rt;
            ex_data1_d = op1;
            ex_data2_d = op2;
            ex_imm_d   = {{(DATA_W-4){rt[3]}}, rt};
            ex_ctrl_d  = if_id_valid ? dec_ctrl : '0;
        end
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_valid_q  <= 1'b0;
            ex_pc_q     <= '0;
            ex_rd_q     <= '0;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            ex_data1_q  <= '0;
            ex_data2_q  <= '0;
            ex_imm_q    <= '0;
            ex_ctrl_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_pc_q     <= ex_pc_d;
            ex_rd_q     <= ex_rd_d;
            ex_rs_q     <= ex_rs_d;
            ex_rt_q     <= ex_rt_d;
            ex_data1_q  <= ex_data1_d;
            ex_data2_q  <= ex_data2_d;
            ex_imm_q    <= ex_imm_d;
            ex_ctrl_q   <= ex_ctrl_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_pc        = ex_pc_q;
    assign ex_rd        = ex_rd_q;
    assign ex_rs        = ex_rs_q;
    assign ex_rt        = ex_rt_q;
    assign ex_data1     = ex_data1_q;
    assign ex_data2     = ex_data2_q;
    assign ex_imm       = ex_imm_q;
    assign ex_alu_op    = ex_ctrl_q.alu_op;
    assign ex_alu_src   = ex_ctrl_q.alu_src;
    assign ex_reg_write = ex_ctrl_q.reg_write;
    assign ex_mem_read  = ex_ctrl_q.mem_read;
    assign ex_mem_write = ex_ctrl_q.mem_write;
    assign ex_branch    = ex_ctrl_q.branch;
    assign stall_count  = stall_cnt_q;

endmodule
